stopwatch_cmd_ctrl: RTL and testbench
=====================================

Name: stopwatch_cmd_ctrl

Overview:
- Multi-channel successor to the single-stopwatch PS/2 command decoder.
- Takes decoded ASCII key bytes from the PS/2 keyboard path, qualified by a one-cycle valid strobe.
- Runs one IDLE/RUN/PAUSE state machine per stopwatch channel, with channel select, broadcast, lap capture and unknown-key error flagging.
- Sits between the PS/2 keyboard decoder and N stopwatch counter/display blocks.

Parameters:
- DATA_W, 8, key data width.
- N_CH, 2, number of stopwatch channels; legal range 1..9.
- KEY_RESET, 8'h0D, Enter: clear the targeted channels.
- KEY_START, 8'h73, 's': start/resume.
- KEY_STOP, 8'h74, 't': pause.
- KEY_LAP, 8'h6C, 'l': lap capture strobe.
- KEY_ALL, 8'h61, 'a': enable broadcast to all channels.
- KEY_SEL0, 8'h31, '1': select key for channel 0; channel k uses KEY_SEL0+k.

Ports:
- clk, input, 1, system clock.
- rst, input, 1, asynchronous active-high reset.
- data, input, DATA_W, ASCII key code from the keyboard decoder.
- data_valid, input, 1, one-cycle strobe per new key press; data is sampled only when high.
- run, output, N_CH, level per channel; 1 while that channel is in RUN.
- clear, output, N_CH, one-cycle pulse per channel: zero the counter.
- lap, output, N_CH, one-cycle pulse per channel: latch the lap value.
- st, output, 2*N_CH, state per channel, channel k at bits [2k+1:2k]; 00=IDLE, 01=RUN, 10=PAUSE.
- sel, output, SW (SW = max(1, clog2(N_CH))), currently selected channel.
- bcast, output, 1, 1 = commands apply to all channels.
- err, output, 1, one-cycle pulse on an unrecognised or out-of-range key.

Behaviour:
- Reset (asynchronous, takes effect immediately; holds while rst=1):
  - every channel IDLE; run=0, clear=0, lap=0, err=0.
  - sel=0, bcast=0.
- All outputs are registered. A command sampled on edge N with data_valid=1 is visible after edge N; pulses are high for exactly that one cycle.
- data_valid=0:
  - no state change.
  - clear, lap and err return to 0.
  - data is ignored regardless of value; a held key does not repeat.
- Target set:
  - bcast=1: all channels.
  - bcast=0: only channel sel.
- Per-channel FSM, applied to each target channel:
  - KEY_RESET: any state -> IDLE, clear pulse=1. Also asserted in IDLE, so a repeated clear is harmless.
  - KEY_START: IDLE -> RUN, PAUSE -> RUN; RUN stays RUN. No pulse.
  - KEY_STOP: RUN -> PAUSE; IDLE and PAUSE unchanged.
  - KEY_LAP: lap pulse=1 only for target channels in RUN; no state change. Ignored in IDLE/PAUSE, and no err.
- Non-target channels hold state and produce no pulses.
- run[k] = (st[k]==RUN), derived from the registered state. There is no extra cycle: run rises on the same edge the state enters RUN.
- Select keys:
  - data == KEY_SEL0+k with k < N_CH: sel<=k, bcast<=0; no channel state change.
  - KEY_SEL0+k with N_CH <= k <= 8: err pulse; sel and bcast unchanged.
- KEY_ALL: bcast<=1, sel unchanged. A later select key clears bcast.
- Any other code with data_valid=1: err pulse; no state change.
  - This replaces the old default-to-start behaviour: unknown keys never start a channel.
- Keys are checked in priority order RESET, START, STOP, LAP, ALL, select, then error. The key parameters must be distinct; the only collision case is a parameter misconfiguration.
- Broadcast with mixed channel states: each channel applies its own transition independently. Example: STOP moves RUN channels to PAUSE and leaves IDLE channels unchanged.
- Reset mid-operation: pulses in flight are cut immediately and all channels return to IDLE. No clear pulse is generated by rst; the counters use rst directly.
- N_CH=1:
  - sel is 1 bit, constant 0.
  - '1' selects channel 0; '2'..'9' give err.
  - bcast is functionally equivalent to sel=0.

Test Plan:
1. Reset, then set N_CH=2 and send 's' -> st[1:0]=01, run=2'b01, other outputs 0; then send 't' -> st[1:0]=10, run=0.
2. Send '2','s','l' -> sel=1, run=2'b10, lap=2'b10 for exactly one cycle; then send 'l' to PAUSE-state channel 0 after '1' -> lap=0, err=0.
3. Send 'a','s', then '1','t', then 'a', Enter -> run=2'b11; then run=2'b10 with ch0 PAUSE; then clear=2'b11 for one cycle, both IDLE, bcast=1.
4. Send 'x' (8'h78) and '5' with N_CH=2 -> err pulses one cycle each; st, sel and bcast unchanged; run stays 0 (no start).
5. Hold data=8'h73 with data_valid=0 for 10 cycles -> no state change; then give data_valid one cycle -> exactly one transition, with the register update on the following edge.
6. While channels are RUN with a lap pulse pending, assert rst asynchronously mid-cycle -> run, lap, sel and bcast go to 0 immediately, before the next clock edge; after release, 'l' -> no lap (IDLE).

Source files
------------

// File: rtl/stopwatch_cmd_ctrl.sv
// rtl/stopwatch_cmd_ctrl.sv - PS/2 key command decoder driving N stopwatch channels
// Per-channel IDLE/RUN/PAUSE machines with select, broadcast, lap and error flagging.
module stopwatch_cmd_ctrl #(
   parameter int                DATA_W    = 8,
   parameter int                N_CH      = 2,
   parameter logic [DATA_W-1:0] KEY_RESET = 8'h0D,
   parameter logic [DATA_W-1:0] KEY_START = 8'h73,
   parameter logic [DATA_W-1:0] KEY_STOP  = 8'h74,
   parameter logic [DATA_W-1:0] KEY_LAP   = 8'h6C,
   parameter logic [DATA_W-1:0] KEY_ALL   = 8'h61,
   parameter logic [DATA_W-1:0] KEY_SEL0  = 8'h31,
   localparam int               SW        = (N_CH > 1) ? $clog2(N_CH) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DATA_W-1:0] data,
   input  logic              data_valid,
   output logic [N_CH-1:0]   run,
   output logic [N_CH-1:0]   clear,
   output logic [N_CH-1:0]   lap,
   output logic [2*N_CH-1:0] st,
   output logic [SW-1:0]     sel,
   output logic              bcast,
   output logic              err
);

   typedef enum logic [1:0] {
      ST_IDLE  = 2'b00,
      ST_RUN   = 2'b01,
      ST_PAUSE = 2'b10
   } state_t;

   state_t            st_q [N_CH];
   state_t            st_d [N_CH];
   logic [N_CH-1:0]   clear_q, clear_d;
   logic [N_CH-1:0]   lap_q, lap_d;
   logic              err_q, err_d;
   logic [SW-1:0]     sel_q, sel_d;
   logic              bcast_q, bcast_d;
   logic [N_CH-1:0]   tgt;
   logic [DATA_W-1:0] sel_idx;

   // Keys below KEY_SEL0 wrap to a large index, so they land in the error branch.
   assign sel_idx = data - KEY_SEL0;

   always_comb begin
      tgt = '0;
      for (int k = 0; k < N_CH; k++) begin
         tgt[k] = bcast_q || (sel_q == SW'(k));
      end
   end

   always_comb begin
      st_d    = st_q;
      sel_d   = sel_q;
      bcast_d = bcast_q;
      clear_d = '0;
      lap_d   = '0;
      err_d   = 1'b0;
      if (data_valid) begin
         if (data == KEY_RESET) begin
            for (int k = 0; k < N_CH; k++) begin
               if (tgt[k]) begin
                  st_d[k]    = ST_IDLE;
                  clear_d[k] = 1'b1;
               end
            end
         end else if (data == KEY_START) begin
            for (int k = 0; k < N_CH; k++) begin
               if (tgt[k]) st_d[k] = ST_RUN;
            end
         end else if (data == KEY_STOP) begin
            for (int k = 0; k < N_CH; k++) begin
               if (tgt[k] && st_q[k] == ST_RUN) st_d[k] = ST_PAUSE;
            end
         end else if (data == KEY_LAP) begin
            for (int k = 0; k < N_CH; k++) begin
               if (tgt[k] && st_q[k] == ST_RUN) lap_d[k] = 1'b1;
            end
         end else if (data == KEY_ALL) begin
            bcast_d = 1'b1;
         end else if (sel_idx < DATA_W'(N_CH)) begin
            sel_d   = sel_idx[SW-1:0];
            bcast_d = 1'b0;
         end else begin
            err_d = 1'b1;
         end
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < N_CH; k++) begin
            st_q[k] <= ST_IDLE;
         end
         clear_q <= '0;
         lap_q   <= '0;
         err_q   <= 1'b0;
         sel_q   <= '0;
         bcast_q <= 1'b0;
      end else begin
         for (int k = 0; k < N_CH; k++) begin
            st_q[k] <= st_d[k];
         end
         clear_q <= clear_d;
         lap_q   <= lap_d;
         err_q   <= err_d;
         sel_q   <= sel_d;
         bcast_q <= bcast_d;
      end
   end

   always_comb begin
      run = '0;
      st  = '0;
      for (int k = 0; k < N_CH; k++) begin
         run[k]       = (st_q[k] == ST_RUN);
         st[2*k +: 2] = st_q[k];
      end
   end

   assign clear = clear_q;
   assign lap   = lap_q;
   assign err   = err_q;
   assign sel   = sel_q;
   assign bcast = bcast_q;

endmodule

// File: tb/tb_stopwatch_cmd_ctrl.sv
// tb/tb_stopwatch_cmd_ctrl.sv - directed vector bench for stopwatch_cmd_ctrl (N_CH=2)
module tb_stopwatch_cmd_ctrl;

   logic       clk;
   logic       rst;
   logic [7:0] data;
   logic       data_valid;
   logic [1:0] run;
   logic [1:0] clear;
   logic [1:0] lap;
   logic [3:0] st;
   logic [0:0] sel;
   logic       bcast;
   logic       err;

   int tests;
   int fails;

   stopwatch_cmd_ctrl #(.DATA_W(8), .N_CH(2)) dut (
      .clk        (clk),
      .rst        (rst),
      .data       (data),
      .data_valid (data_valid),
      .run        (run),
      .clear      (clear),
      .lap        (lap),
      .st         (st),
      .sel        (sel),
      .bcast      (bcast),
      .err        (err)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] key;
      logic       dv;
      logic [1:0] run;
      logic [1:0] clr;
      logic [1:0] lap;
      logic [3:0] st;
      logic       sel;
      logic       bc;
      logic       err;
      string      name;
   } vec_t;

   vec_t vecs[$];

   // Field order in the packed view: run clear lap st sel bcast err
   task automatic check(input string name, input logic [1:0] e_run, input logic [1:0] e_clr,
                        input logic [1:0] e_lap, input logic [3:0] e_st, input logic e_sel,
                        input logic e_bc, input logic e_err);
      logic [12:0] got;
      logic [12:0] exp;
      got = {run, clear, lap, st, sel, bcast, err};
      exp = {e_run, e_clr, e_lap, e_st, e_sel, e_bc, e_err};
      tests++;
      if (got !== exp) begin
         fails++;
         $display("FAIL %s: got run/clr/lap/st/sel/bc/err=%b required %b", name, got, exp);
      end
   endtask

   task automatic apply(input logic [7:0] key, input logic dv);
      @(negedge clk);
      data       = key;
      data_valid = dv;
      @(negedge clk);
      data_valid = 1'b0;
   endtask

   initial begin
      tests      = 0;
      fails      = 0;
      rst        = 1'b1;
      data       = 8'h00;
      data_valid = 1'b0;

      //           key    dv    run    clr    lap    st       sel   bc    err
      vecs.push_back('{8'h73, 1'b1, 2'b01, 2'b00, 2'b00, 4'b0001, 1'b0, 1'b0, 1'b0, "t1_start_ch0"});
      vecs.push_back('{8'h74, 1'b1, 2'b00, 2'b00, 2'b00, 4'b0010, 1'b0, 1'b0, 1'b0, "t1_stop_ch0"});
      vecs.push_back('{8'h32, 1'b1, 2'b00, 2'b00, 2'b00, 4'b0010, 1'b1, 1'b0, 1'b0, "t2_sel1"});
      vecs.push_back('{8'h73, 1'b1, 2'b10, 2'b00, 2'b00, 4'b0110, 1'b1, 1'b0, 1'b0, "t2_start_ch1"});
      vecs.push_back('{8'h6C, 1'b1, 2'b10, 2'b00, 2'b10, 4'b0110, 1'b1, 1'b0, 1'b0, "t2_lap_ch1"});
      vecs.push_back('{8'h6C, 1'b0, 2'b10, 2'b00, 2'b00, 4'b0110, 1'b1, 1'b0, 1'b0, "t2_lap_one_cycle"});
      vecs.push_back('{8'h31, 1'b1, 2'b10, 2'b00, 2'b00, 4'b0110, 1'b0, 1'b0, 1'b0, "t2_sel0"});
      vecs.push_back('{8'h6C, 1'b1, 2'b10, 2'b00, 2'b00, 4'b0110, 1'b0, 1'b0, 1'b0, "t2_lap_in_pause"});
      vecs.push_back('{8'h61, 1'b1, 2'b10, 2'b00, 2'b00, 4'b0110, 1'b0, 1'b1, 1'b0, "t3_all"});
      vecs.push_back('{8'h73, 1'b1, 2'b11, 2'b00, 2'b00, 4'b0101, 1'b0, 1'b1, 1'b0, "t3_start_all"});
      vecs.push_back('{8'h31, 1'b1, 2'b11, 2'b00, 2'b00, 4'b0101, 1'b0, 1'b0, 1'b0, "t3_sel_clears_bcast"});
      vecs.push_back('{8'h74, 1'b1, 2'b10, 2'b00, 2'b00, 4'b0110, 1'b0, 1'b0, 1'b0, "t3_stop_ch0"});
      vecs.push_back('{8'h61, 1'b1, 2'b10, 2'b00, 2'b00, 4'b0110, 1'b0, 1'b1, 1'b0, "t3_all_again"});
      vecs.push_back('{8'h0D, 1'b1, 2'b00, 2'b11, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, "t3_clear_all"});
      vecs.push_back('{8'h0D, 1'b0, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, "t3_clear_one_cycle"});
      vecs.push_back('{8'h73, 1'b1, 2'b11, 2'b00, 2'b00, 4'b0101, 1'b0, 1'b1, 1'b0, "bc_start_both"});
      vecs.push_back('{8'h31, 1'b1, 2'b11, 2'b00, 2'b00, 4'b0101, 1'b0, 1'b0, 1'b0, "bc_sel0"});
      vecs.push_back('{8'h74, 1'b1, 2'b10, 2'b00, 2'b00, 4'b0110, 1'b0, 1'b0, 1'b0, "bc_stop0"});
      vecs.push_back('{8'h61, 1'b1, 2'b10, 2'b00, 2'b00, 4'b0110, 1'b0, 1'b1, 1'b0, "bc_all"});
      vecs.push_back('{8'h6C, 1'b1, 2'b10, 2'b00, 2'b10, 4'b0110, 1'b0, 1'b1, 1'b0, "bc_lap_mixed"});
      vecs.push_back('{8'h74, 1'b1, 2'b00, 2'b00, 2'b00, 4'b1010, 1'b0, 1'b1, 1'b0, "bc_stop_mixed"});
      vecs.push_back('{8'h0D, 1'b1, 2'b00, 2'b11, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, "bc_clear"});
      vecs.push_back('{8'h78, 1'b1, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b1, "t4_unknown_x"});
      vecs.push_back('{8'h78, 1'b0, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b0, "t4_err_one_cycle"});
      vecs.push_back('{8'h35, 1'b1, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b1, "t4_sel_out_of_range"});
      vecs.push_back('{8'h39, 1'b1, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b1, "sel_key_9"});
      vecs.push_back('{8'h30, 1'b1, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b1, 1'b1, "key_0_below_sel"});
      vecs.push_back('{8'h32, 1'b1, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, "sel1_again"});
      vecs.push_back('{8'h74, 1'b1, 2'b00, 2'b00, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, "stop_in_idle"});
      vecs.push_back('{8'h0D, 1'b1, 2'b00, 2'b10, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0, "clear_idle_ch1"});

      repeat (2) @(negedge clk);
      check("reset_held", 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      check("after_reset", 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);

      foreach (vecs[i]) begin
         apply(vecs[i].key, vecs[i].dv);
         check(vecs[i].name, vecs[i].run, vecs[i].clr, vecs[i].lap, vecs[i].st,
               vecs[i].sel, vecs[i].bc, vecs[i].err);
      end

      // Held key with data_valid low must never act; one strobe acts once, on the next edge.
      data       = 8'h73;
      data_valid = 1'b0;
      for (int c = 0; c < 10; c++) begin
         @(negedge clk);
         check($sformatf("t5_held_no_valid_%0d", c), 2'b00, 2'b00, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0);
      end
      data_valid = 1'b1;
      #1;
      check("t5_no_comb_path", 2'b00, 2'b00, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0);
      @(negedge clk);
      data_valid = 1'b0;
      check("t5_single_start", 2'b10, 2'b00, 2'b00, 4'b0100, 1'b1, 1'b0, 1'b0);
      repeat (3) @(negedge clk);
      check("t5_no_repeat", 2'b10, 2'b00, 2'b00, 4'b0100, 1'b1, 1'b0, 1'b0);

      // Async reset lands mid-cycle while a lap pulse is high.
      apply(8'h61, 1'b1);
      check("t6_all", 2'b10, 2'b00, 2'b00, 4'b0100, 1'b1, 1'b1, 1'b0);
      apply(8'h73, 1'b1);
      check("t6_start_all", 2'b11, 2'b00, 2'b00, 4'b0101, 1'b1, 1'b1, 1'b0);
      apply(8'h6C, 1'b1);
      check("t6_lap_pending", 2'b11, 2'b00, 2'b11, 4'b0101, 1'b1, 1'b1, 1'b0);
      #1;
      rst = 1'b1;
      #1;
      check("t6_async_reset", 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      apply(8'h6C, 1'b1);
      check("t6_lap_after_reset", 2'b00, 2'b00, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
